// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: sigma function select and the rotate/shift
// amounts for SHA-256 (32-bit) and SHA-512 (64-bit) words.
package sha2_pkg;

   typedef enum logic [1:0] {
      SIG_BIG0   = 2'd0,
      SIG_BIG1   = 2'd1,
      SIG_SMALL0 = 2'd2,
      SIG_SMALL1 = 2'd3
   } sigma_op_t;

   // Indexed [function][term]; for the small sigmas the third term is a
   // logical right shift rather than a rotate.
   localparam int unsigned SHA512_AMT [4][3] = '{
      '{28, 34, 39},
      '{14, 18, 41},
      '{ 1,  8,  7},
      '{19, 61,  6}
   };

   localparam int unsigned SHA256_AMT [4][3] = '{
      '{ 2, 13, 22},
      '{ 6, 11, 25},
      '{ 7, 18,  3},
      '{17, 19, 10}
   };

endpackage

// File: rtl/sigma_core.sv
// Combinational SHA-2 sigma function for 32- or 64-bit words.
// SIGMA_PIPE_SMALL_EN builds the small sigmas; otherwise op 2/3 yield 0.
module sigma_core
   import sha2_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] x,
   input  sigma_op_t        op,
   output logic [WIDTH-1:0] y
);

   if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
      $error("sigma_core: WIDTH must be 32 or 64");
   end

   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v,
                                             input int unsigned n);
      return (v >> n) | (v << (WIDTH - n));
   endfunction

   function automatic int unsigned amt(input int unsigned f, input int unsigned k);
      return (WIDTH == 64) ? SHA512_AMT[f][k] : SHA256_AMT[f][k];
   endfunction

   always_comb begin
      y = '0;
      case (op)
         SIG_BIG0:   y = rotr(x, amt(0, 0)) ^ rotr(x, amt(0, 1)) ^ rotr(x, amt(0, 2));
         SIG_BIG1:   y = rotr(x, amt(1, 0)) ^ rotr(x, amt(1, 1)) ^ rotr(x, amt(1, 2));
`ifdef SIGMA_PIPE_SMALL_EN
         SIG_SMALL0: y = rotr(x, amt(2, 0)) ^ rotr(x, amt(2, 1)) ^ (x >> amt(2, 2));
         SIG_SMALL1: y = rotr(x, amt(3, 0)) ^ rotr(x, amt(3, 1)) ^ (x >> amt(3, 2));
`endif
         default:    y = '0;
      endcase
   end

endmodule

// File: rtl/sigma_pipe.sv
// Pipelined SHA-2 sigma unit with valid/ready handshake and tag pass-through.
// SIGMA_PIPE_SMALL_EN enables the small sigma functions in sigma_core.
module sigma_pipe
   import sha2_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [TAG_W-1:0] out_tag
);

   if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("sigma_pipe: STAGES must be in 1..3");
   end

   logic [WIDTH-1:0]  f_y;
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0]  y_q [STAGES];
   logic [TAG_W-1:0]  t_q [STAGES];

   sigma_core #(.WIDTH(WIDTH)) u_core (
      .x  (in_x),
      .op (sigma_op_t'(in_op)),
      .y  (f_y)
   );

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_y;
      logic [TAG_W-1:0] src_t;

      // A stage may load iff some stage at or beyond it is empty, or the
      // output drains; flattened so the chain has no self-referencing vector.
      always_comb ld[k] = out_ready | ~(&vld[STAGES-1:k]);

      if (k == 0) begin : g_head
         always_comb begin
            src_v = in_valid;
            src_y = f_y;
            src_t = in_tag;
         end
      end else begin : g_body
         always_comb begin
            src_v = vld[k-1];
            src_y = y_q[k-1];
            src_t = t_q[k-1];
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            vld[k] <= 1'b0;
            y_q[k] <= '0;
            t_q[k] <= '0;
         end else if (ld[k]) begin
            vld[k] <= src_v;
            y_q[k] <= src_y;
            t_q[k] <= src_t;
         end
      end
   end

   always_comb begin
      in_ready  = ld[0];
      out_valid = vld[STAGES-1];
      out_y     = y_q[STAGES-1];
      out_tag   = t_q[STAGES-1];
   end

endmodule

// File: tb/tb_sigma_pipe.sv
// Self-checking bench for sigma_pipe: a 64-bit/2-stage and a 32-bit/3-stage
// instance checked against a queue-based reference model.
module tb_sigma_pipe;

`ifdef SIGMA_PIPE_SMALL_EN
   localparam bit SMALL = 1'b1;
`else
   localparam bit SMALL = 1'b0;
`endif
   localparam int unsigned S64 = 2;
   localparam int unsigned S32 = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  op;
   logic [3:0]  tag;
   logic        iv64, ir64, ov64, or64;
   logic [63:0] x64, y64;
   logic [3:0]  otag64;
   logic        iv32, ir32, ov32, or32;
   logic [31:0] x32, y32;
   logic [3:0]  otag32;

   always #5 clk = ~clk;

   sigma_pipe #(.WIDTH(64), .STAGES(S64), .TAG_W(4)) u64 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv64), .in_ready(ir64), .in_x(x64), .in_op(op), .in_tag(tag),
      .out_valid(ov64), .out_ready(or64), .out_y(y64), .out_tag(otag64)
   );

   sigma_pipe #(.WIDTH(32), .STAGES(S32), .TAG_W(4)) u32 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv32), .in_ready(ir32), .in_x(x32), .in_op(op), .in_tag(tag),
      .out_valid(ov32), .out_ready(or32), .out_y(y32), .out_tag(otag32)
   );

   typedef struct {
      logic [63:0] y;
      logic [3:0]  t;
      int unsigned acc;
   } item_t;

   item_t       q64[$];
   item_t       q32[$];
   int unsigned cyc;
   int unsigned out32_cnt;
   int          checks;
   int          failures;

   function automatic logic [63:0] rr64(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [31:0] rr32(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic logic [63:0] ref64(input logic [63:0] v, input logic [1:0] o);
      case (o)
         2'd0:    return rr64(v, 28) ^ rr64(v, 34) ^ rr64(v, 39);
         2'd1:    return rr64(v, 14) ^ rr64(v, 18) ^ rr64(v, 41);
         2'd2:    return SMALL ? (rr64(v, 1) ^ rr64(v, 8) ^ (v >> 7)) : 64'h0;
         default: return SMALL ? (rr64(v, 19) ^ rr64(v, 61) ^ (v >> 6)) : 64'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref32(input logic [31:0] v, input logic [1:0] o);
      case (o)
         2'd0:    return rr32(v, 2) ^ rr32(v, 13) ^ rr32(v, 22);
         2'd1:    return rr32(v, 6) ^ rr32(v, 11) ^ rr32(v, 25);
         2'd2:    return SMALL ? (rr32(v, 7) ^ rr32(v, 18) ^ (v >> 3)) : 32'h0;
         default: return SMALL ? (rr32(v, 17) ^ rr32(v, 19) ^ (v >> 10)) : 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   // One clock: check outputs against the model, then advance the model by
   // the handshakes the model predicts for this edge.
   task automatic cycle();
      logic e_ir64, e_ov64, e_ir32, e_ov32;
      item_t it;
      #1;
      e_ir64 = (q64.size() < S64) || or64;
      e_ov64 = 1'b0;
      if (q64.size() != 0) e_ov64 = (cyc - q64[0].acc) >= (S64 - 1);
      chk("d64_in_ready", 64'(ir64), 64'(e_ir64));
      chk("d64_out_valid", 64'(ov64), 64'(e_ov64));
      if (e_ov64) begin
         chk("d64_out_y", y64, q64[0].y);
         chk("d64_out_tag", 64'(otag64), 64'(q64[0].t));
      end
      e_ir32 = (q32.size() < S32) || or32;
      e_ov32 = 1'b0;
      if (q32.size() != 0) e_ov32 = (cyc - q32[0].acc) >= (S32 - 1);
      chk("d32_in_ready", 64'(ir32), 64'(e_ir32));
      chk("d32_out_valid", 64'(ov32), 64'(e_ov32));
      if (e_ov32) begin
         chk("d32_out_y", 64'(y32), q32[0].y);
         chk("d32_out_tag", 64'(otag32), 64'(q32[0].t));
      end
      if (ov32 === 1'b1 && or32 === 1'b1) out32_cnt++;
      @(posedge clk);
      cyc++;
      if (e_ov64 && or64) void'(q64.pop_front());
      if (e_ov32 && or32) void'(q32.pop_front());
      if (iv64 && e_ir64) begin
         it.y = ref64(x64, op); it.t = tag; it.acc = cyc;
         q64.push_back(it);
      end
      if (iv32 && e_ir32) begin
         it.y = 64'(ref32(x32, op)); it.t = tag; it.acc = cyc;
         q32.push_back(it);
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      iv64 = 1'b0;
      iv32 = 1'b0;
      @(posedge clk);
      cyc++;
      q64.delete();
      q32.delete();
      #1;
      reset_n = 1'b1;
      #1;
      chk("rst_d64_out_valid", 64'(ov64), 64'h0);
      chk("rst_d64_out_y", y64, 64'h0);
      chk("rst_d64_out_tag", 64'(otag64), 64'h0);
      chk("rst_d64_in_ready", 64'(ir64), 64'h1);
      chk("rst_d32_out_valid", 64'(ov32), 64'h0);
      chk("rst_d32_out_y", 64'(y32), 64'h0);
      chk("rst_d32_in_ready", 64'(ir32), 64'h1);
   endtask

   task automatic probe(input logic [63:0] xa, input logic [31:0] xb, input logic [1:0] o,
                        input logic [3:0] t, input logic [63:0] e64, input logic [31:0] e32);
      x64 = xa; x32 = xb; op = o; tag = t;
      iv64 = 1'b1; iv32 = 1'b1; or64 = 1'b1; or32 = 1'b1;
      cycle();
      iv64 = 1'b0; iv32 = 1'b0;
      repeat (S64 - 1) cycle();
      #1;
      chk("lit_d64_valid", 64'(ov64), 64'h1);
      chk("lit_d64_y", y64, e64);
      chk("lit_d64_tag", 64'(otag64), 64'(t));
      repeat (S32 - S64) cycle();
      #1;
      chk("lit_d32_valid", 64'(ov32), 64'h1);
      chk("lit_d32_y", 64'(y32), 64'(e32));
      chk("lit_d32_tag", 64'(otag32), 64'(t));
      cycle();
      cycle();
   endtask

   initial begin
      int unsigned next_tag;
      checks = 0; failures = 0; cyc = 0; out32_cnt = 0;
      op = 2'd0; tag = 4'd0; x64 = '0; x32 = '0;
      iv64 = 1'b0; iv32 = 1'b0; or64 = 1'b1; or32 = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Known-answer vectors, one per function
      probe(64'h1, 32'h6a09e667, 2'd0, 4'd5, 64'h0000_0010_4200_0000, 32'hce20b47e);
      probe(64'h1, 32'h510e527f, 2'd1, 4'd9, 64'h0004_4000_0080_0000, 32'h3587272b);
      probe(64'h1, 32'h00000400, 2'd2, 4'd3,
            SMALL ? 64'h8100_0000_0000_0000 : 64'h0, SMALL ? 32'h0100_0088 : 32'h0);
      probe(64'h1, 32'h00000400, 2'd3, 4'd12,
            SMALL ? 64'h0000_2000_0000_0008 : 64'h0, SMALL ? 32'h0280_0001 : 32'h0);

      // Backpressure on the 3-stage instance: stream tags 0..7
      or32 = 1'b0; iv64 = 1'b0; next_tag = 0; out32_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         iv32 = 1'b1; tag = 4'(next_tag); op = 2'($urandom_range(0, 3)); x32 = $urandom();
         cycle();
         if (q32.size() > next_tag) next_tag++;
      end
      #1;
      chk("bp_in_ready_low", 64'(ir32), 64'h0);
      chk("bp_accepted", 64'(next_tag), 64'(S32));
      or32 = 1'b1;
      for (int i = 0; i < 40 && (next_tag < 8 || q32.size() != 0); i++) begin
         iv32 = (next_tag < 8);
         tag = 4'(next_tag); op = 2'($urandom_range(0, 3)); x32 = $urandom();
         cycle();
         if (iv32 && ir32 === 1'b1 && next_tag < 8) next_tag++;
      end
      iv32 = 1'b0;
      chk("bp_drained_all", 64'(out32_cnt), 64'd8);
      chk("bp_queue_empty", 64'(q32.size()), 64'd0);

      // Full pipe on the 2-stage instance, then accept and drain together
      iv64 = 1'b1; or64 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         x64 = {$urandom(), $urandom()}; op = 2'($urandom_range(0, 3)); tag = 4'($urandom_range(0, 15));
         cycle();
      end
      or64 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         x64 = {$urandom(), $urandom()}; op = 2'($urandom_range(0, 3)); tag = 4'($urandom_range(0, 15));
         #1;
         chk("full_accept_and_drain", 64'(ir64 & ov64), 64'h1);
         cycle();
      end
      iv64 = 1'b0;
      repeat (3) cycle();

      // Random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         iv64 = 1'($urandom_range(0, 1)); iv32 = 1'($urandom_range(0, 1));
         or64 = ($urandom_range(0, 3) != 0); or32 = ($urandom_range(0, 2) != 0);
         x64 = {$urandom(), $urandom()}; x32 = $urandom();
         op = 2'($urandom_range(0, 3)); tag = 4'($urandom_range(0, 15));
         cycle();
      end

      // Reset with two requests in flight; they must never emerge
      iv64 = 1'b1; iv32 = 1'b1; or64 = 1'b0; or32 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tag = 4'(10 + i); x64 = {$urandom(), $urandom()}; x32 = $urandom();
         cycle();
      end
      do_reset();
      or64 = 1'b1; or32 = 1'b1;
      iv64 = 1'b1; iv32 = 1'b1; tag = 4'd1; op = 2'd0; x64 = 64'h1; x32 = 32'h6a09e667;
      cycle();
      iv64 = 1'b0; iv32 = 1'b0;
      repeat (5) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
